owmc_weight_ctrl: RTL and testbench

- On-chip weight memory controller for the CNN accelerator.
- Captures a stream of filter weights into a local RAM.
- On request, replays them one channel-slice at a time onto an output bus, with a mux enable and select, so downstream weight registers can load.
- Uses handshake flags (done / ok) for both phases toward the top-level sequencer.

---
 rtl/owmc_pkg.sv | 21 ++
 rtl/owmc_weight_ctrl_if.sv | 43 ++++
 rtl/owmc_weight_ram.sv | 39 +++
 rtl/owmc_weight_ctrl.sv | 161 ++++++++++++++++
 tb/tb_owmc_weight_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/owmc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | owmc_pkg : shared state encoding and default widths for OWMC     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package owmc_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MEM_SIZE   = 169;
    localparam int DEF_ADDR_WIDTH = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        W_DONE = 3'd2,
        LOAD_R = 3'd3,
        R_DONE = 3'd4
    } owmc_state_t;

endpackage
`default_nettype wire

// File: rtl/owmc_weight_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | owmc_weight_ctrl_if : sequencer <-> weight controller bundle     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface owmc_weight_ctrl_if
    import owmc_pkg::*;
#(
    parameter int W_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int W_ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic [W_ADDR_WIDTH-1:0] OWMC_W_Size;
    logic [W_ADDR_WIDTH-1:0] OWMC_W_COXRW;
    logic [W_DATA_WIDTH-1:0] OWMC_Input_Data;
    logic                    OWMC_Start_Loading_Weights;
    logic                    OWMC_Start_Loading_Regs;
    logic                    OWMC_Loading_Weights_Already_Ok;
    logic                    OWMC_Loading_Regs_Already_Ok;
    logic                    OWMC_Loading_Weights_Already;
    logic                    OWMC_Loading_Regs_Already;
    logic [W_DATA_WIDTH-1:0] OWMC_Output_Data;
    logic                    OWMC_Muxes_En;
    logic [W_ADDR_WIDTH-1:0] OWMC_Muxes_Sel;

    modport master (
        output OWMC_W_Size, OWMC_W_COXRW, OWMC_Input_Data,
        output OWMC_Start_Loading_Weights, OWMC_Start_Loading_Regs,
        output OWMC_Loading_Weights_Already_Ok, OWMC_Loading_Regs_Already_Ok,
        input  OWMC_Loading_Weights_Already, OWMC_Loading_Regs_Already,
        input  OWMC_Output_Data, OWMC_Muxes_En, OWMC_Muxes_Sel
    );

    modport slave (
        input  OWMC_W_Size, OWMC_W_COXRW, OWMC_Input_Data,
        input  OWMC_Start_Loading_Weights, OWMC_Start_Loading_Regs,
        input  OWMC_Loading_Weights_Already_Ok, OWMC_Loading_Regs_Already_Ok,
        output OWMC_Loading_Weights_Already, OWMC_Loading_Regs_Already,
        output OWMC_Output_Data, OWMC_Muxes_En, OWMC_Muxes_Sel
    );

endinterface
`default_nettype wire

// File: rtl/owmc_weight_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | owmc_weight_ram : single-port weight RAM, sync write/read, no rst|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module owmc_weight_ram
    import owmc_pkg::*;
#(
    parameter int W_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int W_MEM_SIZE   = DEF_MEM_SIZE,
    parameter int W_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [W_ADDR_WIDTH-1:0] addr,
    input  logic [W_DATA_WIDTH-1:0] wdata,
    output logic [W_DATA_WIDTH-1:0] rdata
);

    localparam int                    IDX_WIDTH = $clog2(W_MEM_SIZE);
    localparam logic [W_ADDR_WIDTH-1:0] MEM_LAST = W_ADDR_WIDTH'(W_MEM_SIZE - 1);

    logic [W_DATA_WIDTH-1:0] mem [W_MEM_SIZE];
    logic                    in_range;
    logic [IDX_WIDTH-1:0]    idx;

    // Out-of-range addresses neither write nor read real storage
    assign in_range = (addr <= MEM_LAST);
    assign idx      = addr[IDX_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
        rdata <= in_range ? mem[idx] : '0;
    end

endmodule
`default_nettype wire

// File: rtl/owmc_weight_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | owmc_weight_ctrl : captures weight stream, replays channel slices|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module owmc_weight_ctrl
    import owmc_pkg::*;
#(
    parameter int W_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int W_MEM_SIZE   = DEF_MEM_SIZE,
    parameter int W_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic              OWMC_Clk,
    input  logic              OWMC_Reset,
    owmc_weight_ctrl_if.slave bus
);

    owmc_state_t             state, state_n;
    logic [W_ADDR_WIDTH-1:0] wr_cnt, wr_cnt_n;
    logic [W_ADDR_WIDTH-1:0] rd_cnt, rd_cnt_n;
    logic [W_ADDR_WIDTH-1:0] rd_ptr, rd_ptr_n;
    logic [W_ADDR_WIDTH-1:0] size_q, size_n;
    logic [W_ADDR_WIDTH-1:0] coxrw_q, coxrw_n;
    logic                    flag_w, flag_w_n;
    logic                    flag_r, flag_r_n;
    logic                    en, en_n;
    logic [W_ADDR_WIDTH-1:0] sel, sel_n;
    logic [W_DATA_WIDTH-1:0] out_data, out_data_n;

    logic                    ram_we;
    logic [W_ADDR_WIDTH-1:0] ram_addr;
    logic [W_DATA_WIDTH-1:0] ram_rdata;
    logic [W_ADDR_WIDTH:0]   ptr_sum;

    assign ptr_sum = {1'b0, rd_ptr} + {1'b0, coxrw_q} + 1'b1;

    owmc_weight_ram #(
        .W_DATA_WIDTH (W_DATA_WIDTH),
        .W_MEM_SIZE   (W_MEM_SIZE),
        .W_ADDR_WIDTH (W_ADDR_WIDTH)
    ) u_ram (
        .clk   (OWMC_Clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.OWMC_Input_Data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge OWMC_Clk) begin
        if (OWMC_Reset) begin
            state    <= IDLE;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            rd_ptr   <= '0;
            size_q   <= '0;
            coxrw_q  <= '0;
            flag_w   <= 1'b0;
            flag_r   <= 1'b0;
            en       <= 1'b0;
            sel      <= '0;
            out_data <= '0;
        end else begin
            state    <= state_n;
            wr_cnt   <= wr_cnt_n;
            rd_cnt   <= rd_cnt_n;
            rd_ptr   <= rd_ptr_n;
            size_q   <= size_n;
            coxrw_q  <= coxrw_n;
            flag_w   <= flag_w_n;
            flag_r   <= flag_r_n;
            en       <= en_n;
            sel      <= sel_n;
            out_data <= out_data_n;
        end
    end

    // The RAM address is presented one cycle ahead of each output word so the
    // registered read plus the output register still land at E(k+1).
    always_comb begin
        state_n    = state;
        wr_cnt_n   = wr_cnt;
        rd_cnt_n   = rd_cnt;
        rd_ptr_n   = rd_ptr;
        size_n     = size_q;
        coxrw_n    = coxrw_q;
        flag_w_n   = 1'b0;
        flag_r_n   = 1'b0;
        en_n       = 1'b0;
        sel_n      = '0;
        out_data_n = '0;
        ram_we     = 1'b0;
        ram_addr   = rd_ptr;

        case (state)
            IDLE: begin
                if (bus.OWMC_Start_Loading_Weights) begin
                    size_n   = bus.OWMC_W_Size;
                    ram_we   = 1'b1;
                    ram_addr = '0;
                    wr_cnt_n = W_ADDR_WIDTH'(1);
                    rd_ptr_n = '0;
                    state_n  = (bus.OWMC_W_Size == '0) ? W_DONE : LOAD_W;
                end else if (bus.OWMC_Start_Loading_Regs) begin
                    coxrw_n  = bus.OWMC_W_COXRW;
                    rd_cnt_n = '0;
                    state_n  = LOAD_R;
                end
            end
            LOAD_W: begin
                ram_we   = 1'b1;
                ram_addr = wr_cnt;
                wr_cnt_n = wr_cnt + 1'b1;
                if (wr_cnt == size_q) begin
                    state_n = W_DONE;
                end
            end
            W_DONE: begin
                if (bus.OWMC_Loading_Weights_Already_Ok) begin
                    state_n = IDLE;
                end else begin
                    flag_w_n = 1'b1;
                end
            end
            LOAD_R: begin
                en_n       = 1'b1;
                sel_n      = rd_cnt;
                out_data_n = ram_rdata;
                ram_addr   = rd_ptr + rd_cnt + 1'b1;
                if (rd_cnt == coxrw_q) begin
                    state_n  = R_DONE;
                    rd_cnt_n = '0;
                    rd_ptr_n = (ptr_sum > {1'b0, size_q}) ? '0 : ptr_sum[W_ADDR_WIDTH-1:0];
                end else begin
                    rd_cnt_n = rd_cnt + 1'b1;
                end
            end
            R_DONE: begin
                if (bus.OWMC_Loading_Regs_Already_Ok) begin
                    state_n = IDLE;
                end else begin
                    flag_r_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (OWMC_Reset) begin
            ram_we = 1'b0;
        end
    end

    assign bus.OWMC_Loading_Weights_Already = flag_w;
    assign bus.OWMC_Loading_Regs_Already    = flag_r;
    assign bus.OWMC_Output_Data             = out_data;
    assign bus.OWMC_Muxes_En                = en;
    assign bus.OWMC_Muxes_Sel               = sel;

endmodule
`default_nettype wire

// File: tb/tb_owmc_weight_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_owmc_weight_ctrl : scoreboard bench for owmc_weight_ctrl      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_owmc_weight_ctrl;
    import owmc_pkg::*;

    localparam int DW = 8;
    localparam int AW = 9;
    localparam int MS = 169;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    owmc_weight_ctrl_if #(.W_DATA_WIDTH(DW), .W_ADDR_WIDTH(AW)) bus ();

    owmc_weight_ctrl #(
        .W_DATA_WIDTH (DW),
        .W_MEM_SIZE   (MS),
        .W_ADDR_WIDTH (AW)
    ) dut (
        .OWMC_Clk   (clk),
        .OWMC_Reset (rst),
        .bus        (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] sel;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks    = 0;
    int            errors    = 0;
    int            en_count  = 0;
    logic [DW-1:0] model_mem [MS];
    int            model_ptr = 0;
    int            model_size = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every En cycle must match the next queued word
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.OWMC_Muxes_En) begin
                en_count++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_en", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("slice_data", 32'(bus.OWMC_Output_Data), 32'(mon_e.data));
                    check_eq("slice_sel", 32'(bus.OWMC_Muxes_Sel), 32'(mon_e.sel));
                end
            end else begin
                check_eq("bus_zero_when_idle", 32'({bus.OWMC_Output_Data, bus.OWMC_Muxes_Sel}), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_idle();
        bus.OWMC_W_Size                     = '0;
        bus.OWMC_W_COXRW                    = '0;
        bus.OWMC_Input_Data                 = '0;
        bus.OWMC_Start_Loading_Weights      = 1'b0;
        bus.OWMC_Start_Loading_Regs         = 1'b0;
        bus.OWMC_Loading_Weights_Already_Ok = 1'b0;
        bus.OWMC_Loading_Regs_Already_Ok    = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        check_eq("rst_flag_w", 32'(bus.OWMC_Loading_Weights_Already), 32'd0);
        check_eq("rst_flag_r", 32'(bus.OWMC_Loading_Regs_Already), 32'd0);
        check_eq("rst_en", 32'(bus.OWMC_Muxes_En), 32'd0);
        check_eq("rst_data", 32'(bus.OWMC_Output_Data), 32'd0);
        check_eq("rst_sel", 32'(bus.OWMC_Muxes_Sel), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        model_ptr = 0;
    endtask

    task automatic load_weights(input int n, input int base, input int step,
                                input bit poke_regs, input bit both_starts);
        @(negedge clk);
        bus.OWMC_W_Size = AW'(n - 1);
        for (int i = 0; i < n; i++) begin
            bus.OWMC_Start_Loading_Weights = (i == 0);
            bus.OWMC_Start_Loading_Regs    = both_starts && (i == 0);
            bus.OWMC_Input_Data            = DW'(base + step * i);
            model_mem[i]                   = DW'(base + step * i);
            @(negedge clk);
        end
        bus.OWMC_Start_Loading_Weights = 1'b0;
        bus.OWMC_Start_Loading_Regs    = 1'b0;
        bus.OWMC_Input_Data            = 'z;
        check_eq("wload_flag_early", 32'(bus.OWMC_Loading_Weights_Already), 32'd0);
        @(negedge clk);
        check_eq("wload_flag_set", 32'(bus.OWMC_Loading_Weights_Already), 32'd1);
        if (poke_regs) begin
            bus.OWMC_W_COXRW            = AW'(2);
            bus.OWMC_Start_Loading_Regs = 1'b1;
            @(negedge clk);
            bus.OWMC_Start_Loading_Regs = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_eq("wload_flag_hold", 32'(bus.OWMC_Loading_Weights_Already), 32'd1);
        bus.OWMC_Loading_Weights_Already_Ok = 1'b1;
        @(negedge clk);
        bus.OWMC_Loading_Weights_Already_Ok = 1'b0;
        check_eq("wload_flag_clear", 32'(bus.OWMC_Loading_Weights_Already), 32'd0);
        check_eq("wload_no_rflag", 32'(bus.OWMC_Loading_Regs_Already), 32'd0);
        model_ptr  = 0;
        model_size = n - 1;
    endtask

    task automatic load_slice(input int coxrw);
        int   cyc;
        int   seen;
        exp_t e;
        @(negedge clk);
        bus.OWMC_W_COXRW            = AW'(coxrw);
        bus.OWMC_Start_Loading_Regs = 1'b1;
        for (int k = 0; k <= coxrw; k++) begin
            e.data = model_mem[model_ptr + k];
            e.sel  = AW'(k);
            exp_q.push_back(e);
        end
        model_ptr = model_ptr + coxrw + 1;
        if (model_ptr > model_size) model_ptr = 0;
        en_count = 0;
        @(negedge clk);
        bus.OWMC_Start_Loading_Regs = 1'b0;
        cyc  = 0;
        seen = 0;
        for (int j = 1; j <= 400; j++) begin
            @(negedge clk);
            if (bus.OWMC_Loading_Regs_Already) begin
                cyc  = j;
                seen = 1;
                break;
            end
        end
        check_eq("rload_flag_seen", 32'(seen), 32'd1);
        check_eq("rload_latency", 32'(cyc), 32'(coxrw + 2));
        check_eq("rload_en_cycles", 32'(en_count), 32'(coxrw + 1));
        check_eq("rload_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("rload_flag_hold", 32'(bus.OWMC_Loading_Regs_Already), 32'd1);
        bus.OWMC_Loading_Regs_Already_Ok = 1'b1;
        @(negedge clk);
        bus.OWMC_Loading_Regs_Already_Ok = 1'b0;
        check_eq("rload_flag_clear", 32'(bus.OWMC_Loading_Regs_Already), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        drive_idle();
        @(negedge clk);
        reset_dut();

        // Basic load of 10..120 then four slices, the last one wrapping
        load_weights(12, 10, 10, 1'b0, 1'b0);
        load_slice(3);
        load_slice(3);
        load_slice(3);
        load_slice(3);

        // Reset two words into a slice; rd_ptr returns to 0, RAM survives
        begin
            exp_t e;
            @(negedge clk);
            bus.OWMC_W_COXRW            = AW'(3);
            bus.OWMC_Start_Loading_Regs = 1'b1;
            for (int k = 0; k < 2; k++) begin
                e.data = model_mem[model_ptr + k];
                e.sel  = AW'(k);
                exp_q.push_back(e);
            end
            @(negedge clk);
            bus.OWMC_Start_Loading_Regs = 1'b0;
            repeat (2) @(negedge clk);
            #1;
            rst = 1'b1;
            @(negedge clk);
            check_eq("midrst_en", 32'(bus.OWMC_Muxes_En), 32'd0);
            check_eq("midrst_flag_r", 32'(bus.OWMC_Loading_Regs_Already), 32'd0);
            check_eq("midrst_flag_w", 32'(bus.OWMC_Loading_Weights_Already), 32'd0);
            check_eq("midrst_data", 32'(bus.OWMC_Output_Data), 32'd0);
            check_eq("midrst_words", 32'(exp_q.size()), 32'd0);
            rst = 1'b0;
            exp_q.delete();
            model_ptr = 0;
        end
        load_slice(3);

        // Regs start during W_DONE and stray Oks in IDLE are ignored
        load_weights(12, 3, 7, 1'b1, 1'b0);
        @(negedge clk);
        bus.OWMC_Loading_Weights_Already_Ok = 1'b1;
        bus.OWMC_Loading_Regs_Already_Ok    = 1'b1;
        @(negedge clk);
        bus.OWMC_Loading_Weights_Already_Ok = 1'b0;
        bus.OWMC_Loading_Regs_Already_Ok    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("stray_ok_flag_w", 32'(bus.OWMC_Loading_Weights_Already), 32'd0);
        check_eq("stray_ok_flag_r", 32'(bus.OWMC_Loading_Regs_Already), 32'd0);
        check_eq("stray_ok_en", 32'(bus.OWMC_Muxes_En), 32'd0);
        load_slice(5);
        load_slice(5);

        // Both starts together: the weight load wins
        load_weights(3, 8'hA1, 1, 1'b0, 1'b1);
        load_slice(2);

        // Single-word load and single-word slices
        load_weights(1, 8'h5A, 0, 1'b0, 1'b0);
        load_slice(0);
        load_slice(0);

        // Whole RAM, last address included, read back in one slice
        load_weights(MS, 1, 3, 1'b0, 1'b0);
        load_slice(MS - 1);
        load_slice(0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
